// File: rtl/m_imem_loader.sv
// Byte-stream program loader: takes a little-endian word count N, then N little-endian words,
// and writes them to IMEM addresses 0..N-1 while holding the core in reset.
module m_imem_loader #(
  parameter int WIDTH = 32,
  parameter int ENTRY = 256,
  localparam int AW = $clog2(ENTRY)
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             I_START,
  input  logic             I_VALID,
  input  logic [7:0]       I_DATA,
  output logic             O_READY,
  output logic             O_WE,
  output logic [AW-1:0]    O_WADDR,
  output logic [WIDTH-1:0] O_WDATA,
  output logic             O_CORE_RST_X,
  output logic             O_DONE,
  output logic             O_ERR
);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] n_len;
  logic [23:0] shbuf;
  logic        accept, last_byte;
  logic [31:0] len_full;
  logic [31:0] word_full;

  assign accept    = I_VALID & O_READY;
  assign last_byte = (byte_cnt == 2'd3);
  // Both the length and the data word are shifted in LSB first, so the top byte arrives last.
  assign len_full  = {I_DATA, n_len[31:8]};
  assign word_full = {I_DATA, shbuf};

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= S_LEN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:  if (accept && last_byte) state_nxt = (len_full == 32'd0) ? S_DONE : S_DATA;
      S_DATA: if (accept && last_byte && (word_cnt == n_len - 32'd1)) state_nxt = S_DONE;
      S_DONE: if (I_START) state_nxt = S_LEN;
      default: state_nxt = S_LEN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      byte_cnt     <= 2'd0;
      word_cnt     <= 32'd0;
      n_len        <= 32'd0;
      shbuf        <= 24'd0;
      O_READY      <= 1'b0;
      O_WE         <= 1'b0;
      O_WADDR      <= '0;
      O_WDATA      <= '0;
      O_CORE_RST_X <= 1'b0;
      O_DONE       <= 1'b0;
      O_ERR        <= 1'b0;
    end else begin
      O_WE         <= 1'b0;
      // Ready and status lead the state by one edge so they are valid in the state's first cycle.
      O_READY      <= (state_nxt != S_DONE);
      O_DONE       <= (state_nxt == S_DONE);
      O_CORE_RST_X <= (state_nxt == S_DONE);
      if (accept) byte_cnt <= byte_cnt + 2'd1;
      case (state)
        S_LEN: if (accept) begin
          n_len <= len_full;
          if (last_byte) begin
            word_cnt <= 32'd0;
            if (len_full > 32'(ENTRY)) O_ERR <= 1'b1;
          end
        end
        S_DATA: if (accept) begin
          shbuf <= word_full[31:8];
          if (last_byte) begin
            word_cnt <= word_cnt + 32'd1;
            // Words past the end of IMEM are consumed but never written.
            if (word_cnt < 32'(ENTRY)) begin
              O_WE    <= 1'b1;
              O_WADDR <= word_cnt[AW-1:0];
              O_WDATA <= word_full;
            end
          end
        end
        S_DONE: if (I_START) begin
          byte_cnt <= 2'd0;
          word_cnt <= 32'd0;
          n_len    <= 32'd0;
          O_ERR    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
